issue_hazard_ctrl: RTL and testbench
====================================

// Module: issue_hazard_ctrl
// PURPOSE
//  Decode-stage issue controller: per-register scoreboard between decoder and EX.
//  Decides each cycle whether the decoded instr issues or stalls (RAW, WAW, backpressure).
//  Covers ALU (fully bypassed), load (load-use bubble) and the multi-cycle MUL pipe.
//  Consumes decoder fields (rs1/rs2/rd, opcode class); drives decode/fetch stall and EX valid.
// PARAMETERS
//  NUM_REGS  32  architectural regs; x0 never tracked
//  LOAD_LAT  2   cycles until load data bypassable; scoreboard count = LOAD_LAT-1
//  MUL_LAT   5   MUL pipe depth; scoreboard count = MUL_LAT-1
//  CNT_W     3   counter width; require MUL_LAT-1 <= 2**CNT_W-1 (elab-time $error otherwise)
// PORTS
//  clk        in   1                      clock
//  rst        in   1                      sync active-high reset
//  dec_valid  in   1                      decode holds a valid instr
//  rs1        in   `ARCH_REG_INDEX_SIZE   source 1 index
//  rs2        in   `ARCH_REG_INDEX_SIZE   source 2 index
//  rd         in   `ARCH_REG_INDEX_SIZE   destination index
//  uses_rs1   in   1                      instr reads rs1 (R/I/S/B types)
//  uses_rs2   in   1                      instr reads rs2 (R/S/B types)
//  writes_rd  in   1                      instr writes rd (R/I/J types, load)
//  is_load    in   1                      opcode == `OPCODE_LOAD
//  is_mul     in   1                      `OPCODE_ALU with funct7 == `MUL_FUNCT7
//  ex_ready   in   1                      EX accepts (0 = whole back end frozen, e.g. D$ miss)
//  flush      in   1                      kill instr in decode (taken branch/jump)
//  issue      out  1                      instr enters EX this cycle
//  stall      out  1                      hold PC and IF/ID register
//  raw_hazard out  1                      RAW hazard detected (debug)
//  waw_hazard out  1                      WAW hazard detected (debug)
// BEHAVIOUR
//  - State: cnt[r], r=1..NUM_REGS-1, CNT_W bits = remaining bubbles before r bypassable.
//  - Reset: all cnt=0; issue=0, stall=0 (outputs combinational from state + inputs).
//  - raw_hazard = dec_valid & ((uses_rs1 & rs1!=0 & cnt[rs1]!=0) | (uses_rs2 & rs2!=0 & cnt[rs2]!=0)).
//  - lat_new = is_mul ? MUL_LAT-1 : is_load ? LOAD_LAT-1 : 0.
//  - waw_hazard = dec_valid & writes_rd & rd!=0 & cnt[rd] > lat_new (keeps WB in order).
//  - issue = dec_valid & ex_ready & ~flush & ~raw_hazard & ~waw_hazard.
//  - stall = dec_valid & ~flush & (raw_hazard | waw_hazard | ~ex_ready).
//  - flush has priority: issue=0, stall=0, scoreboard not written; in-flight counts keep decaying.
//  - Per cycle, ex_ready=1: every nonzero cnt decrements by 1; ex_ready=0: all cnt hold.
//  - On issue with writes_rd & rd!=0: cnt[rd] <= lat_new, overriding that reg's decrement.
//  - Zero-latency (ALU) writes leave cnt[rd]=0: back-to-back dependent ALU ops issue every cycle.
//  - Decision latency 0 cycles; scoreboard update visible next cycle.
//  - Counters saturate at 0, never wrap; rs==rd of same instr checked against pre-update cnt.
//  - rst mid-stall clears all counts; next cycle any valid instr issues if ex_ready=1.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds out ports raw_stall_cycles, waw_stall_cycles,
//   bp_stall_cycles (`WORD_SIZE each); +1 per cycle stall=1 by cause, priority raw>waw>backpressure;
//   wrap at 2**`WORD_SIZE; cleared by rst.
//  Undefined: ports and counters absent; remaining behaviour identical.
// TESTING
//  1 mul x2,x3,x4 (0x02418133) issued, then add x5,x2,x1 held -> stall=1 for 4 cycles,
//    issue=1 on cycle 5 after mul issue.
//  2 lw x1,1(x3) (0x0011a083) then addi x1,x1,1 (0x00108093) -> exactly 1 stall cycle, raw_hazard=1.
//  3 add x1,x2,x3 then add x4,x1,x1 then sub x2,x3,x4 -> issue every cycle, stall never 1.
//  4 mul x2,.. then addi x2,x0,1 next cycle -> waw_hazard=1, issue after 4 cycles;
//    x0 dest (j, 0xff5ff06f) never stalls.
//  5 mul x2 issued, ex_ready=0 for 3 cycles, dependent add waiting -> cnt[2] frozen,
//    total stall 7 cycles.
//  6 RAW-stalled add with flush=1 -> issue=0, stall=0; rst during MUL stall -> next-cycle issue=1.

Source files
------------

// File: rtl/issue_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | issue_hazard_ctrl: decode-stage per-register scoreboard deciding issue or  |
// | stall (RAW/WAW/backpressure). Optional perf counters: HAZARD_PERF_CNT_EN.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module issue_hazard_ctrl #(
   parameter int NUM_REGS = 32,
   parameter int LOAD_LAT = 2,
   parameter int MUL_LAT  = 5,
   parameter int CNT_W    = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            dec_valid,
   input  logic [`ARCH_REG_INDEX_SIZE-1:0] rs1,
   input  logic [`ARCH_REG_INDEX_SIZE-1:0] rs2,
   input  logic [`ARCH_REG_INDEX_SIZE-1:0] rd,
   input  logic                            uses_rs1,
   input  logic                            uses_rs2,
   input  logic                            writes_rd,
   input  logic                            is_load,
   input  logic                            is_mul,
   input  logic                            ex_ready,
   input  logic                            flush,
   output logic                            issue,
   output logic                            stall,
   output logic                            raw_hazard,
   output logic                            waw_hazard
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [`WORD_SIZE-1:0]           raw_stall_cycles,
   output logic [`WORD_SIZE-1:0]           waw_stall_cycles,
   output logic [`WORD_SIZE-1:0]           bp_stall_cycles
`endif
);

   localparam logic [CNT_W-1:0] c_mul_cnt  = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] c_load_cnt = CNT_W'(LOAD_LAT - 1);

   generate
      if ((MUL_LAT - 1) > (2**CNT_W - 1) || (LOAD_LAT - 1) > (2**CNT_W - 1)) begin : g_cnt_w_check
         $error("issue_hazard_ctrl: CNT_W too narrow for MUL_LAT/LOAD_LAT");
      end
   endgenerate

   // Entry 0 exists only so rs/rd can index directly; it is held at zero.
   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];

   logic [CNT_W-1:0] w_lat_new;
   logic             w_rs1_busy;
   logic             w_rs2_busy;

   always_comb begin
      w_lat_new  = is_mul ? c_mul_cnt : (is_load ? c_load_cnt : '0);
      w_rs1_busy = uses_rs1 && (rs1 != '0) && (cnt_q[rs1] != '0);
      w_rs2_busy = uses_rs2 && (rs2 != '0) && (cnt_q[rs2] != '0);
      raw_hazard = dec_valid && (w_rs1_busy || w_rs2_busy);
      // A newer write must not retire before an older, longer-latency one.
      waw_hazard = dec_valid && writes_rd && (rd != '0) && (cnt_q[rd] > w_lat_new);
      issue      = dec_valid && ex_ready && !flush && !raw_hazard && !waw_hazard;
      stall      = dec_valid && !flush && (raw_hazard || waw_hazard || !ex_ready);
   end

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (ex_ready && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end
      end
      if (issue && writes_rd && (rd != '0)) begin
         cnt_d[rd] = w_lat_new;
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [`WORD_SIZE-1:0] raw_cnt_q;
   logic [`WORD_SIZE-1:0] waw_cnt_q;
   logic [`WORD_SIZE-1:0] bp_cnt_q;

   // Each stalled cycle is charged to exactly one cause, RAW first.
   always_ff @(posedge clk) begin
      if (rst) begin
         raw_cnt_q <= '0;
         waw_cnt_q <= '0;
         bp_cnt_q  <= '0;
      end else if (stall) begin
         if (raw_hazard) begin
            raw_cnt_q <= raw_cnt_q + 1'b1;
         end else if (waw_hazard) begin
            waw_cnt_q <= waw_cnt_q + 1'b1;
         end else begin
            bp_cnt_q <= bp_cnt_q + 1'b1;
         end
      end
   end

   assign raw_stall_cycles = raw_cnt_q;
   assign waw_stall_cycles = waw_cnt_q;
   assign bp_stall_cycles  = bp_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_issue_hazard_ctrl: scoreboard bench for issue_hazard_ctrl.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_issue_hazard_ctrl;

   localparam logic [31:0] MUL_X2  = 32'h02418133; // mul  x2,x3,x4
   localparam logic [31:0] ADD_X5  = 32'h001102B3; // add  x5,x2,x1
   localparam logic [31:0] LW_X1   = 32'h0011a083; // lw   x1,1(x3)
   localparam logic [31:0] ADDI_X1 = 32'h00108093; // addi x1,x1,1
   localparam logic [31:0] ADD_X1  = 32'h003100B3; // add  x1,x2,x3
   localparam logic [31:0] ADD_X4  = 32'h00108233; // add  x4,x1,x1
   localparam logic [31:0] SUB_X2  = 32'h40418133; // sub  x2,x3,x4
   localparam logic [31:0] ADDI_X2 = 32'h00100113; // addi x2,x0,1
   localparam logic [31:0] J_X0    = 32'hff5ff06f; // j    -12

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dec_valid = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       uses_rs1 = 1'b0, uses_rs2 = 1'b0, writes_rd = 1'b0;
   logic       is_load = 1'b0, is_mul = 1'b0;
   logic       ex_ready = 1'b1, flush = 1'b0;
   logic       issue, stall, raw_hazard, waw_hazard;

   logic [3:0] sb [$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   issue_hazard_ctrl dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd),
      .is_load(is_load), .is_mul(is_mul), .ex_ready(ex_ready), .flush(flush),
      .issue(issue), .stall(stall), .raw_hazard(raw_hazard), .waw_hazard(waw_hazard)
   );

   // Step: {rst, valid, ex_ready, flush, expected {issue,stall,raw,waw}, instr}
   function automatic logic [39:0] st(input bit r, input bit v, input bit exr, input bit fl,
                                      input logic [3:0] e, input logic [31:0] ins);
      return {r, v, exr, fl, e, ins};
   endfunction

   task automatic drive(input logic [39:0] s);
      logic [31:0] ins;
      logic [6:0]  op;
      ins = s[31:0];
      op  = ins[6:0];
      @(posedge clk);
      #1;
      rst = s[39]; dec_valid = s[38]; ex_ready = s[37]; flush = s[36];
      rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
      uses_rs1 = 1'b0; uses_rs2 = 1'b0; writes_rd = 1'b0; is_load = 1'b0; is_mul = 1'b0;
      if (s[38]) begin
         case (op)
            7'h33: begin
               uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
               is_mul = (ins[31:25] == 7'h01);
            end
            7'h13: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            7'h03: begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
            7'h6f: writes_rd = 1'b1;
            7'h63, 7'h23: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default: ;
         endcase
      end
      sb.push_back(s[35:32]);
   endtask

   task automatic test_reset();
      logic [39:0] t [$];
      logic [3:0]  e;
      t.push_back(st(1, 0, 1, 0, 4'b0000, 32'h0));
      t.push_back(st(1, 0, 1, 0, 4'b0000, 32'h0));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADD_X5));
      t.push_back(st(0, 0, 1, 0, 4'b0000, 32'h0));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({issue, stall, raw_hazard, waw_hazard} !== e) begin
            errors++;
            $display("FAIL reset step %0d: {issue,stall,raw,waw}=%b expected %b", i,
                     {issue, stall, raw_hazard, waw_hazard}, e);
         end
      end
   endtask

   task automatic test_mul_raw();
      logic [39:0] t [$];
      logic [3:0]  e;
      t.push_back(st(0, 1, 1, 0, 4'b1000, MUL_X2));
      for (int k = 0; k < 4; k++) t.push_back(st(0, 1, 1, 0, 4'b0110, ADD_X5));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADD_X5));
      t.push_back(st(0, 0, 1, 0, 4'b0000, 32'h0));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({issue, stall, raw_hazard, waw_hazard} !== e) begin
            errors++;
            $display("FAIL mul_raw step %0d: {issue,stall,raw,waw}=%b expected %b", i,
                     {issue, stall, raw_hazard, waw_hazard}, e);
         end
      end
   endtask

   task automatic test_load_use();
      logic [39:0] t [$];
      logic [3:0]  e;
      // addi x1,x1,1 both reads and rewrites x1, so RAW and WAW fire together.
      t.push_back(st(0, 1, 1, 0, 4'b1000, LW_X1));
      t.push_back(st(0, 1, 1, 0, 4'b0111, ADDI_X1));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADDI_X1));
      t.push_back(st(0, 0, 1, 0, 4'b0000, 32'h0));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({issue, stall, raw_hazard, waw_hazard} !== e) begin
            errors++;
            $display("FAIL load_use step %0d: {issue,stall,raw,waw}=%b expected %b", i,
                     {issue, stall, raw_hazard, waw_hazard}, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [39:0] t [$];
      logic [3:0]  e;
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADD_X1));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADD_X4));
      t.push_back(st(0, 1, 1, 0, 4'b1000, SUB_X2));
      t.push_back(st(0, 0, 1, 0, 4'b0000, 32'h0));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({issue, stall, raw_hazard, waw_hazard} !== e) begin
            errors++;
            $display("FAIL back_to_back step %0d: {issue,stall,raw,waw}=%b expected %b", i,
                     {issue, stall, raw_hazard, waw_hazard}, e);
         end
      end
   endtask

   task automatic test_waw();
      logic [39:0] t [$];
      logic [3:0]  e;
      t.push_back(st(0, 1, 1, 0, 4'b1000, MUL_X2));
      for (int k = 0; k < 4; k++) t.push_back(st(0, 1, 1, 0, 4'b0101, ADDI_X2));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADDI_X2));
      t.push_back(st(0, 1, 1, 0, 4'b1000, J_X0));
      t.push_back(st(0, 1, 1, 0, 4'b1000, MUL_X2));
      t.push_back(st(0, 1, 1, 0, 4'b1000, J_X0));
      for (int k = 0; k < 4; k++) t.push_back(st(0, 0, 1, 0, 4'b0000, 32'h0));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({issue, stall, raw_hazard, waw_hazard} !== e) begin
            errors++;
            $display("FAIL waw step %0d: {issue,stall,raw,waw}=%b expected %b", i,
                     {issue, stall, raw_hazard, waw_hazard}, e);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [39:0] t [$];
      logic [3:0]  e;
      t.push_back(st(0, 1, 1, 0, 4'b1000, MUL_X2));
      t.push_back(st(0, 1, 1, 0, 4'b0110, ADD_X5));
      for (int k = 0; k < 3; k++) t.push_back(st(0, 1, 0, 0, 4'b0110, ADD_X5));
      for (int k = 0; k < 3; k++) t.push_back(st(0, 1, 1, 0, 4'b0110, ADD_X5));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADD_X5));
      t.push_back(st(0, 1, 0, 0, 4'b0100, ADD_X4));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADD_X4));
      t.push_back(st(0, 0, 1, 0, 4'b0000, 32'h0));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({issue, stall, raw_hazard, waw_hazard} !== e) begin
            errors++;
            $display("FAIL backpressure step %0d: {issue,stall,raw,waw}=%b expected %b", i,
                     {issue, stall, raw_hazard, waw_hazard}, e);
         end
      end
   endtask

   task automatic test_flush_reset();
      logic [39:0] t [$];
      logic [3:0]  e;
      // Flushed mul must not mark x2 busy.
      t.push_back(st(0, 1, 1, 1, 4'b0000, MUL_X2));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADD_X5));
      // Count keeps decaying through the flushed cycle: 4 -> 3 stalls remain.
      t.push_back(st(0, 1, 1, 0, 4'b1000, MUL_X2));
      t.push_back(st(0, 1, 1, 1, 4'b0010, ADD_X5));
      for (int k = 0; k < 3; k++) t.push_back(st(0, 1, 1, 0, 4'b0110, ADD_X5));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADD_X5));
      t.push_back(st(0, 1, 1, 0, 4'b1000, MUL_X2));
      t.push_back(st(0, 1, 1, 0, 4'b0110, ADD_X5));
      t.push_back(st(1, 1, 1, 0, 4'b0110, ADD_X5));
      t.push_back(st(0, 1, 1, 0, 4'b1000, ADD_X5));
      t.push_back(st(0, 0, 1, 0, 4'b0000, 32'h0));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({issue, stall, raw_hazard, waw_hazard} !== e) begin
            errors++;
            $display("FAIL flush_reset step %0d: {issue,stall,raw,waw}=%b expected %b", i,
                     {issue, stall, raw_hazard, waw_hazard}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul_raw();
      test_load_use();
      test_back_to_back();
      test_waw();
      test_backpressure();
      test_flush_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
